instr_fetch_seq: RTL
====================

INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, fetch address loaded on reset.
REQ-002 clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 imem_req  output  1  instruction-memory read request; registered.
REQ-005 imem_addr  output  16  word address of the outstanding read; registered.
REQ-006 imem_ack  input  1  memory response strobe; imem_data is valid in the same cycle.
REQ-007 imem_data  input  16  instruction word; OpCode field is [15:12].
REQ-008 stall  input  1  downstream not ready; holds the issued instruction.
REQ-009 take_branch  input  1  redirect request from the branch/bra decode path.
REQ-010 branch_target  input  16  redirect address; sampled with take_branch.
REQ-011 OpCode  output  4  opcode of the issued instruction; drives the control-unit OpCode input.
REQ-012 instr  output  16  full issued instruction word.
REQ-013 instr_pc  output  16  address the issued instruction was fetched from.
REQ-014 instr_valid  output  1  OpCode/instr/instr_pc are valid.

Function
REQ-015 The FSM SHALL have three states: FETCH, WAIT and ISSUE; all outputs SHALL be registered.
REQ-016 In FETCH, on the next edge: imem_req<=1, imem_addr<=pc, state<=WAIT.
REQ-017 In WAIT, imem_req and imem_addr SHALL hold stable until a cycle with imem_ack=1; latency is unbounded.
REQ-018 On an edge in WAIT with imem_ack=1: instr<=imem_data, OpCode<=imem_data[15:12], instr_pc<=pc, instr_valid<=1, imem_req<=0, pc<=pc+1, state<=ISSUE.
REQ-019 imem_ack SHALL be ignored in FETCH and ISSUE; no state or output changes result.
REQ-020 In ISSUE with stall=1, all outputs and pc SHALL hold.
REQ-021 In ISSUE with stall=0, the instruction is consumed: instr_valid<=0, state<=FETCH; OpCode, instr and instr_pc hold their last values.
REQ-022 take_branch=1 SHALL be acted on only in a consume cycle (ISSUE, stall=0): pc<=branch_target, overriding pc+1.
REQ-023 take_branch SHALL be ignored when instr_valid=0 or stall=1; the source holds it until consume.
REQ-024 pc+1 SHALL wrap from 16'hFFFF to 16'h0000; branch_target is used unmodified, with no alignment.
REQ-025 Every 4-bit OpCode value, including values undefined for the control unit, SHALL be passed through unmodified.
REQ-026 Minimum throughput is one instruction per 3 cycles (FETCH, WAIT with immediate ack, ISSUE, no stall).

Reset
REQ-027 rst=1 SHALL take precedence over every other input at the edge.
REQ-028 On reset: pc<=RESET_PC, state<=FETCH, imem_req<=0, imem_addr<=0, instr_valid<=0, OpCode<=0, instr<=0, instr_pc<=0.
REQ-029 Reset asserted in WAIT SHALL abandon the read; an imem_ack arriving after reset release, before the new request is issued, SHALL be ignored.
REQ-030 The first imem_req after reset release SHALL rise on the second edge after rst deasserts, with imem_addr=RESET_PC.

Verification
REQ-031 Reset, then ack each request the cycle after imem_req rises, with data 16'h1234, 16'h5ABC -> OpCode=1 with instr_pc=0, then OpCode=5 with instr_pc=1, each instr_valid pulse lasting 1 cycle.
REQ-032 Ack delayed 4 cycles -> imem_req high and imem_addr stable for all 5 WAIT cycles; single instr_valid.
REQ-033 stall=1 for 3 cycles during ISSUE with instr 16'hD00F -> OpCode=13 held 4 cycles, no new imem_req until stall=0.
REQ-034 Issue a branch instr at pc 16'h0010, take_branch=1, branch_target=16'h0080 at consume -> next imem_addr=16'h0080; the same take_branch pulsed while stall=1 has no effect.
REQ-035 RESET_PC=16'hFFFF -> fetches at FFFF then 0000 (wrap).
REQ-036 rst pulsed mid-WAIT, stale ack 1 cycle after release -> ignored; next fetch at RESET_PC; all outputs at reset values.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// instr_fetch_seq
// Instruction fetch sequencer. Reads one instruction word at a time from the
// instruction memory, presents it to the control unit, and advances the
// fetch address. The address either increments or takes a branch redirect
// when the presented instruction is consumed.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   imem_req       instruction-memory read request (registered)
//   imem_addr      word address of the outstanding read (registered)
//   imem_ack       memory response strobe, imem_data valid in the same cycle
//   imem_data      instruction word returned by memory
//   stall          downstream not ready; holds the issued instruction
//   take_branch    redirect request, acted on only when the instruction is consumed
//   branch_target  redirect address, sampled with take_branch
//   OpCode         opcode field [15:12] of the issued instruction (registered)
//   instr          full issued instruction word (registered)
//   instr_pc       fetch address of the issued instruction (registered)
//   instr_valid    OpCode/instr/instr_pc are valid (registered)
// -----------------------------------------------------------------------------
module instr_fetch_seq #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        take_branch,
    input  logic [15:0] branch_target,
    output logic [3:0]  OpCode,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid
);

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Set by reset and cleared one edge after release, so the first request
    // rises on the second edge after rst deasserts and any ack left over from
    // an abandoned read cannot line up with the new request.
    logic            r_boot;

    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   w_pc_nxt;

    logic            w_req_nxt;
    logic [AW-1:0]   w_addr_nxt;
    logic [OPW-1:0]  w_op_nxt;
    logic [DW-1:0]   w_instr_nxt;
    logic [AW-1:0]   w_instr_pc_nxt;
    logic            w_valid_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_boot  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_boot  <= 1'b0;
        end
    end

    // Next-state logic; imem_ack only matters in WAIT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (!r_boot) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Output / datapath next values; everything holds unless a state acts on it
    always_comb begin
        w_req_nxt      = imem_req;
        w_addr_nxt     = imem_addr;
        w_op_nxt       = OpCode;
        w_instr_nxt    = instr;
        w_instr_pc_nxt = instr_pc;
        w_valid_nxt    = instr_valid;
        w_pc_nxt       = r_pc;
        case (r_state)
            S_FETCH: begin
                if (!r_boot) begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = r_pc;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    w_instr_nxt    = imem_data;
                    w_op_nxt       = imem_data[DW-1 -: OPW];
                    w_instr_pc_nxt = r_pc;
                    w_valid_nxt    = 1'b1;
                    w_req_nxt      = 1'b0;
                    // 16-bit add wraps FFFF -> 0000 naturally
                    w_pc_nxt       = r_pc + AW'(1);
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    w_valid_nxt = 1'b0;
                    // pc already points past the issued word; a redirect replaces it
                    if (take_branch) begin
                        w_pc_nxt = branch_target;
                    end
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Output and pc registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            OpCode      <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            imem_req    <= w_req_nxt;
            imem_addr   <= w_addr_nxt;
            OpCode      <= w_op_nxt;
            instr       <= w_instr_nxt;
            instr_pc    <= w_instr_pc_nxt;
            instr_valid <= w_valid_nxt;
        end
    end

endmodule
